core_bus_arbiter_rr: RTL

CORE_BUS_ARBITER_RR -- requirements
Module: core_bus_arbiter_rr

---
 rtl/core_bus_arbiter_rr.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/core_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// core_bus_arbiter_rr
// Shares one single-outstanding bus among N requesting channels. Each channel
// owns a one-deep pending slot. A grant is chosen by fixed priority (MODE=0)
// or by round-robin starting after the last completed channel (MODE=1).
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   ch_start[N]    : per-channel request pulse (fields sampled with it)
//   ch_write/addr/data_wr/data_be : per-channel request fields
//   ch_ready[N]    : completion pulse for the granted channel (same cycle as bus_ready)
//   ch_data_rd     : read data, follows bus_data_rd
//   ch_drop[N]     : pulse, the cycle after a ch_start hit a busy slot
//   bus_addr/write/data_wr/data_be : fields of the granted transfer
//   bus_start      : one-cycle transfer start
//   bus_ready      : transfer completion, bus_data_rd valid with it
//
// state  | meaning
// IDLE   | no transfer; pick a grant when any slot is pending
// ISSUE  | bus_start high for this single cycle
// WAIT   | bus fields held; on bus_ready complete and chain the next grant
// ---------------------------------------------------------------------------
module core_bus_arbiter_rr #(
  parameter int N      = 2,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int MODE   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 ch_start,
  input  logic [N-1:0]                 ch_write,
  input  logic [N-1:0][ADDR_W-1:0]     ch_addr,
  input  logic [N-1:0][DATA_W-1:0]     ch_data_wr,
  input  logic [N-1:0][DATA_W/8-1:0]   ch_data_be,
  output logic [N-1:0]                 ch_ready,
  output logic [DATA_W-1:0]            ch_data_rd,
  output logic [N-1:0]                 ch_drop,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic                         bus_write,
  output logic [DATA_W-1:0]            bus_data_wr,
  output logic [DATA_W/8-1:0]          bus_data_be,
  output logic                         bus_start,
  input  logic                         bus_ready,
  input  logic [DATA_W-1:0]            bus_data_rd
);

  localparam int IDX_W = $clog2(N);
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          grant;
  logic [IDX_W-1:0]          last;
  logic [N-1:0]              pending;
  logic [N-1:0]              slot_write;
  logic [N-1:0][ADDR_W-1:0]  slot_addr;
  logic [N-1:0][DATA_W-1:0]  slot_data_wr;
  logic [N-1:0][BE_W-1:0]    slot_data_be;

  logic                      bus_done;
  logic [N-1:0]              accept;
  logic [N-1:0]              reload;
  logic [N-1:0]              cand;
  logic [IDX_W-1:0]          base;
  logic [IDX_W-1:0]          pick;
  logic                      found;
  int                        arb_idx;
  logic                      sel_write;
  logic [ADDR_W-1:0]         sel_addr;
  logic [DATA_W-1:0]         sel_data_wr;
  logic [BE_W-1:0]           sel_data_be;

  assign bus_done   = (state == S_WAIT) && bus_ready;
  assign ch_ready   = (bus_done && !rst) ? (N'(1) << grant) : '0;
  assign ch_data_rd = bus_data_rd;

  // A slot that completes this cycle may be refilled in the same cycle.
  assign accept = ch_start & (~pending | ch_ready);
  assign reload = ch_start & ch_ready;

  // When chaining out of WAIT, the completing slot only competes again if it
  // is being refilled right now; that request is taken straight from the inputs.
  assign cand = (state == S_WAIT) ? ((pending & ~ch_ready) | reload) : pending;

  always_comb begin
    if (MODE == 0)
      base = IDX_W'(N - 1);
    else if (state == S_WAIT)
      base = grant;
    else
      base = last;
  end

  always_comb begin
    found   = 1'b0;
    pick    = '0;
    arb_idx = 0;
    for (int k = 0; k < N; k++) begin
      arb_idx = (int'(base) + 1 + k) % N;
      if (!found && cand[IDX_W'(arb_idx)]) begin
        found = 1'b1;
        pick  = IDX_W'(arb_idx);
      end
    end
  end

  always_comb begin
    sel_write   = slot_write[pick];
    sel_addr    = slot_addr[pick];
    sel_data_wr = slot_data_wr[pick];
    sel_data_be = slot_data_be[pick];
    if (reload[pick]) begin
      sel_write   = ch_write[pick];
      sel_addr    = ch_addr[pick];
      sel_data_wr = ch_data_wr[pick];
      sel_data_be = ch_data_be[pick];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      grant        <= '0;
      last         <= IDX_W'(N - 1);
      pending      <= '0;
      slot_write   <= '0;
      slot_addr    <= '0;
      slot_data_wr <= '0;
      slot_data_be <= '0;
      ch_drop      <= '0;
      bus_start    <= 1'b0;
      bus_write    <= 1'b0;
      bus_addr     <= '0;
      bus_data_wr  <= '0;
      bus_data_be  <= '0;
    end else begin
      ch_drop   <= ch_start & pending & ~ch_ready;
      bus_start <= 1'b0;
      pending   <= (pending & ~ch_ready) | accept;
      for (int i = 0; i < N; i++) begin
        if (accept[i]) begin
          slot_write[i]   <= ch_write[i];
          slot_addr[i]    <= ch_addr[i];
          slot_data_wr[i] <= ch_data_wr[i];
          slot_data_be[i] <= ch_data_be[i];
        end
      end

      case (state)
        S_IDLE: begin
          if (found) begin
            grant       <= pick;
            bus_start   <= 1'b1;
            bus_write   <= sel_write;
            bus_addr    <= sel_addr;
            bus_data_wr <= sel_data_wr;
            bus_data_be <= sel_data_be;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (bus_ready) begin
            last <= grant;
            if (found) begin
              grant       <= pick;
              bus_start   <= 1'b1;
              bus_write   <= sel_write;
              bus_addr    <= sel_addr;
              bus_data_wr <= sel_data_wr;
              bus_data_be <= sel_data_be;
              state       <= S_ISSUE;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
